// File: rtl/mm_iddmm_pkg.sv
// Shared types and default sizing for the IDDMM sequencer.
package mm_iddmm_pkg;

  localparam int K  = 128;
  localparam int N  = 32;
  localparam int IW = $clog2(N);
  localparam int JW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    JLINE,
    GAP,
    SAVE,
    CMP,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mm_iddmm_subw.sv
// K-bit subtract-with-borrow cell; the borrow register links successive words.
module mm_iddmm_subw #(
  parameter int K = mm_iddmm_pkg::K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] diff,
  output logic         borrow
);

  logic         borrow_q;
  logic [K:0]   full;

  assign full   = {1'b0, a} - {1'b0, b} - {{K{1'b0}}, borrow_q};
  assign diff   = full[K-1:0];
  assign borrow = full[K];

  // Borrow register: clear wins over enable so a chain can end and restart in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      borrow_q <= 1'b0;
    end else if (en) begin
      borrow_q <= full[K];
    end
  end

endmodule

// File: rtl/mm_iddmm_ctrl.sv
// Sequencer for one IDDMM PE: clears A, runs the i/j loops, then word-serial final subtract.
module mm_iddmm_ctrl #(
  parameter int K  = mm_iddmm_pkg::K,
  parameter int N  = mm_iddmm_pkg::N,
  parameter int IW = $clog2(N),
  parameter int JW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] pe_i,
  output logic [JW-1:0] pe_j,
  output logic          pe_j00,
  input  logic [K-1:0]  pe_uj,
  input  logic          pe_carry,
  output logic [JW-1:0] x_addr,
  output logic [IW-1:0] y_addr,
  output logic [JW-1:0] m_addr,
  input  logic [K-1:0]  m_rdata,
  output logic [JW-1:0] a_addr,
  input  logic [K-1:0]  a_rdata,
  output logic          a_we,
  output logic [JW-1:0] a_waddr,
  output logic [K-1:0]  a_wdata,
  output logic          r_we,
  output logic [JW-1:0] r_addr,
  output logic [K-1:0]  r_wdata
);

  import mm_iddmm_pkg::*;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [JW-1:0]   k_q, k_d;
  logic            sel_q, sel_d;

  logic [K-1:0]    sub_b;
  logic [K-1:0]    sub_diff;
  logic            sub_borrow;
  logic            sub_clr;
  logic            sub_en;
  logic            cmp_last;

  assign pe_i   = i_q;
  assign pe_j   = j_q;
  assign x_addr = j_q;
  assign y_addr = i_q;

  // The top word of m does not exist, so the last compare step subtracts zero.
  // The chain is cleared on that same step so WR restarts its borrow at word 0.
  assign cmp_last = (state_q == CMP) && (k_q == JW'(N));
  assign sub_b    = cmp_last ? '0 : m_rdata;
  assign sub_en   = (state_q == CMP) || (state_q == WR);
  assign sub_clr  = !sub_en || cmp_last;

  mm_iddmm_subw #(.K(K)) u_subw (
    .clk    (clk),
    .rst    (rst),
    .clr    (sub_clr),
    .en     (sub_en),
    .a      (a_rdata),
    .b      (sub_b),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // Next-state, counter updates and memory/PE control decode.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    sel_d   = sel_q;
    busy    = (state_q != IDLE) && (state_q != DONE);
    done    = 1'b0;
    pe_j00  = 1'b0;
    a_addr  = j_q;
    m_addr  = j_q;
    a_we    = 1'b0;
    a_waddr = '0;
    a_wdata = '0;
    r_we    = 1'b0;
    r_addr  = '0;
    r_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_d     = '0;
        end
      end
      CLEAR: begin
        a_we    = 1'b1;
        a_waddr = k_q;
        if (k_q == JW'(N)) begin
          state_d = JLINE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          k_d = k_q + JW'(1);
        end
      end
      JLINE: begin
        pe_j00  = (j_q == '0);
        a_we    = (j_q != '0);
        a_waddr = j_q - JW'(1);
        a_wdata = pe_uj;
        if (j_q == JW'(N)) begin
          state_d = GAP;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      GAP: begin
        if (i_q == IW'(N - 1)) begin
          state_d = SAVE;
        end else begin
          i_d     = i_q + IW'(1);
          j_d     = '0;
          state_d = JLINE;
        end
      end
      SAVE: begin
        a_we    = 1'b1;
        a_waddr = JW'(N);
        a_wdata = {{(K-1){1'b0}}, pe_carry};
        k_d     = '0;
        state_d = CMP;
      end
      CMP: begin
        a_addr = k_q;
        m_addr = k_q;
        if (k_q == JW'(N)) begin
          sel_d   = ~sub_borrow;
          k_d     = '0;
          state_d = WR;
        end else begin
          k_d = k_q + JW'(1);
        end
      end
      WR: begin
        a_addr  = k_q;
        m_addr  = k_q;
        r_we    = 1'b1;
        r_addr  = k_q;
        r_wdata = sel_q ? sub_diff : a_rdata;
        if (k_q == JW'(N - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + JW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mm_iddmm_ctrl.sv
// Bench for mm_iddmm_ctrl: stand-in PE and RAMs, cycle-by-cycle output checks, result table.
module tb_mm_iddmm_ctrl;

  localparam int TK   = 8;
  localparam int TN   = 4;
  localparam int TIW  = 2;
  localparam int TJW  = 3;
  localparam int P    = TN + 2;
  localparam int S    = P + TN * (TN + 2);
  localparam int LAT  = S + 2 * TN + 2;
  localparam int NWE  = (TN + 1) + TN * TN + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy, done;
  logic [TIW-1:0]  pe_i;
  logic [TJW-1:0]  pe_j;
  logic            pe_j00;
  logic [TK-1:0]   pe_uj;
  logic            pe_carry;
  logic [TJW-1:0]  x_addr;
  logic [TIW-1:0]  y_addr;
  logic [TJW-1:0]  m_addr;
  logic [TK-1:0]   m_rdata;
  logic [TJW-1:0]  a_addr;
  logic [TK-1:0]   a_rdata;
  logic            a_we;
  logic [TJW-1:0]  a_waddr;
  logic [TK-1:0]   a_wdata;
  logic            r_we;
  logic [TJW-1:0]  r_addr;
  logic [TK-1:0]   r_wdata;

  logic [TK-1:0]      amem [0:TN];
  logic [TK-1:0]      mmem [0:TN];
  logic [TN*TK-1:0]   cur_uj;
  logic               cur_carry;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [TN*TK-1:0] uj;
    logic             carry;
    logic [TN*TK-1:0] m;
    logic [TN*TK-1:0] exp;
  } vec_t;
  vec_t vt [6];

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            j00;
    logic            awe;
    logic            rwe;
    logic [TJW-1:0]  awaddr;
    logic [TK-1:0]   awdata;
    logic [TK-1:0]   ard;
    logic [TJW-1:0]  raddr;
    logic [TIW-1:0]  pi;
    logic [TJW-1:0]  pj;
    logic [TJW-1:0]  aaddr;
    logic [TJW-1:0]  maddr;
    logic [TJW-1:0]  xaddr;
    logic [TIW-1:0]  yaddr;
  } obs_t;

  mm_iddmm_ctrl #(.K(TK), .N(TN), .IW(TIW), .JW(TJW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pe_i     (pe_i),
    .pe_j     (pe_j),
    .pe_j00   (pe_j00),
    .pe_uj    (pe_uj),
    .pe_carry (pe_carry),
    .x_addr   (x_addr),
    .y_addr   (y_addr),
    .m_addr   (m_addr),
    .m_rdata  (m_rdata),
    .a_addr   (a_addr),
    .a_rdata  (a_rdata),
    .a_we     (a_we),
    .a_waddr  (a_waddr),
    .a_wdata  (a_wdata),
    .r_we     (r_we),
    .r_addr   (r_addr),
    .r_wdata  (r_wdata)
  );

  always #5 clk = ~clk;

  // Stand-in PE: the last row emits the table words, earlier rows emit filler.
  function automatic logic [TK-1:0] fpe(input int r, input int c);
    if (r == TN - 1) begin
      if (c >= 1 && c <= TN) return cur_uj[(c-1)*TK +: TK];
      return 8'h5A;
    end
    return TK'(r * 37 + c * 5 + 3);
  endfunction

  assign pe_uj    = fpe(int'(pe_i), int'(pe_j));
  assign pe_carry = cur_carry;
  assign a_rdata  = (int'(a_addr) <= TN) ? amem[a_addr] : '0;
  assign m_rdata  = (int'(m_addr) <= TN) ? mmem[m_addr] : 8'hEE;

  always @(posedge clk) begin
    if (a_we && int'(a_waddr) <= TN) amem[a_waddr] <= a_wdata;
  end

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy;   o.done = done;     o.j00 = pe_j00;    o.awe = a_we;
    o.rwe = r_we;    o.awaddr = a_waddr; o.awdata = a_wdata; o.ard = a_rdata;
    o.raddr = r_addr; o.pi = pe_i;      o.pj = pe_j;       o.aaddr = a_addr;
    o.maddr = m_addr; o.xaddr = x_addr; o.yaddr = y_addr;
    return o;
  endfunction

  // Expected outputs for cycle c after the start edge (c=1 is the first CLEAR cycle).
  function automatic void expect_at(input int c, output obs_t e, output obs_t m);
    int off, row, col, k;
    e = '0;
    m = '0;
    m.busy = 1'b1; m.done = 1'b1; m.j00 = 1'b1; m.awe = 1'b1; m.rwe = 1'b1;
    if (c >= S) begin
      m.pi = '1; m.pj = '1; e.pi = TIW'(TN - 1); e.pj = TJW'(TN);
    end
    if (c >= 1 && c <= TN + 1) begin
      e.busy = 1'b1; e.awe = 1'b1;
      m.awaddr = '1; e.awaddr = TJW'(c - 1);
      m.awdata = '1;
    end else if (c >= P && c < S) begin
      off = c - P; row = off / (TN + 2); col = off % (TN + 2);
      e.busy = 1'b1;
      m.pi = '1; m.pj = '1; e.pi = TIW'(row);
      if (col <= TN) begin
        e.pj = TJW'(col);
        e.j00 = (col == 0);
        e.awe = (col != 0);
        if (col != 0) begin
          m.awaddr = '1; e.awaddr = TJW'(col - 1);
          m.awdata = '1; e.awdata = fpe(row, col);
        end
        m.aaddr = '1; m.maddr = '1; m.xaddr = '1; m.yaddr = '1;
        e.aaddr = TJW'(col); e.maddr = TJW'(col); e.xaddr = TJW'(col); e.yaddr = TIW'(row);
        m.ard = '1;
        e.ard = (row == 0 || col == TN) ? '0 : fpe(row - 1, col + 1);
      end else begin
        e.pj = TJW'(TN);
      end
    end else if (c == S) begin
      e.busy = 1'b1; e.awe = 1'b1;
      m.awaddr = '1; e.awaddr = TJW'(TN);
      m.awdata = '1; e.awdata = TK'(cur_carry);
    end else if (c > S && c <= S + TN + 1) begin
      k = c - S - 1;
      e.busy = 1'b1;
      m.aaddr = '1; m.maddr = '1; e.aaddr = TJW'(k); e.maddr = TJW'(k);
    end else if (c > S + TN + 1 && c < LAT) begin
      k = c - S - TN - 2;
      e.busy = 1'b1; e.rwe = 1'b1;
      m.raddr = '1; e.raddr = TJW'(k);
      m.aaddr = '1; m.maddr = '1; e.aaddr = TJW'(k); e.maddr = TJW'(k);
    end else if (c == LAT) begin
      e.done = 1'b1;
    end
  endfunction

  function automatic void rst_exp(output obs_t e, output obs_t m);
    e = '0;
    m = '1;
    m.ard = '0;
    m.awdata = '0;
  endfunction

  task automatic chk_obs(input string nm, input int c, input obs_t e, input obs_t m);
    obs_t a;
    a = sample();
    total++;
    if (((a ^ e) & m) !== '0) begin
      bad++;
      $display("FAIL %s c=%0d got=%h want=%h mask=%h", nm, c, a, e, m);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic load(input int v);
    cur_uj    = vt[v].uj;
    cur_carry = vt[v].carry;
    for (int k = 0; k < TN; k++) mmem[k] = vt[v].m[k*TK +: TK];
    mmem[TN] = 8'hFF;
  endtask

  // One full operation from start to a couple of idle cycles after done.
  task automatic run_vec(input int v, input int glitch_at);
    obs_t e, m;
    int done_at, done_n, wes;
    logic [TN*TK-1:0] res;
    load(v);
    res = ~vt[v].exp;
    done_at = -1; done_n = 0; wes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      expect_at(c, e, m);
      chk_obs($sformatf("v%0d_cyc", v), c, e, m);
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (a_we) wes++;
      if (r_we && int'(r_addr) < TN) res[int'(r_addr)*TK +: TK] = r_wdata;
      start = (c == glitch_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("v%0d_latency", v), 64'(done_at), 64'(LAT));
    chk($sformatf("v%0d_done_pulses", v), 64'(done_n), 64'd1);
    chk($sformatf("v%0d_a_we_count", v), 64'(wes), 64'(NWE));
    chk($sformatf("v%0d_result", v), 64'(res), 64'(vt[v].exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    obs_t e, m;

    vt[0] = '{uj: 32'h00000001, carry: 1'b0, m: 32'h000000F1, exp: 32'h00000001};
    vt[1] = '{uj: 32'h000000F5, carry: 1'b0, m: 32'h000000F1, exp: 32'h00000004};
    vt[2] = '{uj: 32'h40302010, carry: 1'b1, m: 32'h80000000, exp: 32'hC0302010};
    vt[3] = '{uj: 32'hABCD1234, carry: 1'b0, m: 32'hABCD1234, exp: 32'h00000000};
    vt[4] = '{uj: 32'hABCD1233, carry: 1'b0, m: 32'hABCD1234, exp: 32'hABCD1233};
    vt[5] = '{uj: 32'h00000000, carry: 1'b1, m: 32'h00000001, exp: 32'hFFFFFFFF};

    rst = 1'b1;
    start = 1'b0;
    load(0);
    repeat (3) @(negedge clk);
    rst_exp(e, m);
    chk_obs("reset", 0, e, m);
    rst = 1'b0;
    @(negedge clk);
    chk_obs("idle_after_reset", 0, e, m);

    for (int v = 0; v < 6; v++) begin
      run_vec(v, (v == 1) ? 12 : ((v == 3) ? LAT : 0));
    end

    // Reset in the middle of the PE phase, then a clean run over the stale A.
    load(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      expect_at(c, e, m);
      chk_obs("pre_rst_cyc", c, e, m);
      if (c < 20) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst_exp(e, m);
    chk_obs("mid_run_reset", 0, e, m);
    rst = 1'b0;
    @(negedge clk);
    chk_obs("idle_after_mid_reset", 0, e, m);
    run_vec(4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
